mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between two requesters of the pipelined core:
  - instruction fetch (IF), read only;
  - data memory stage (DM), load or store.
- Sequences every memory access and produces the stall signals the pipeline uses to freeze the fetch and memory stages while a requester waits.
- Sits between the fetch/memory stages and the memory macro; works alongside the load-use hazard logic.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/arb_fixed_pri_starve.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM
  } arb_state_t;

  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_fixed_pri_starve.sv
// Fixed-priority pick (DM over IF) with a starvation counter that forces IF
// through after STARVE_MAX consecutive DM wins.
module arb_fixed_pri_starve
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arb_en,
  input  logic                if_req,
  input  logic                dm_req,
  output logic                grant_if,
  output logic                grant_dm,
  output logic [STARVE_W-1:0] starve_cnt
);

  localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (arb_en) begin
      if (if_req && (!dm_req || starve_cnt == SMAX)) begin
        grant_if = 1'b1;
      end else if (dm_req) begin
        grant_dm = 1'b1;
      end
    end
  end

  // Counts DM wins only while IF is actually waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && starve_cnt != SMAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (IF) and data (DM)
// requesters; one access outstanding, back-to-back issue on the completion cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fe,
  output logic              stall_mem
);

  arb_state_t       state, state_nx;
  logic [LAT_W-1:0] lat_cnt, lat_nx;
  logic             done, arb_en, grant_if, grant_dm, cur_we;
  logic [STARVE_W-1:0] starve_cnt;

  assign done   = (state != IDLE) && (lat_cnt == LAT_W'(1));
  assign arb_en = (state == IDLE) || done;

  arb_fixed_pri_starve #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en),
    .if_req    (if_req),
    .dm_req    (dm_req),
    .grant_if  (grant_if),
    .grant_dm  (grant_dm),
    .starve_cnt(starve_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_nx;
    end
  end

  // A grant on the completion cycle overrides the return to IDLE.
  always_comb begin
    state_nx = state;
    lat_nx   = lat_cnt;
    if (state != IDLE) lat_nx = lat_cnt - 1'b1;
    if (done) state_nx = IDLE;
    if (grant_if) begin
      state_nx = BUSY_IF;
      lat_nx   = LAT_W'(MEM_LAT);
    end else if (grant_dm) begin
      state_nx = BUSY_DM;
      lat_nx   = LAT_W'(MEM_LAT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cur_we    <= 1'b0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ready <= grant_if;
      dm_ready <= grant_dm;
      mem_en   <= grant_if | grant_dm;
      mem_we   <= grant_dm & dm_we;
      if (grant_if) begin
        mem_addr <= if_addr;
      end else if (grant_dm) begin
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        cur_we    <= dm_we;
      end
      if_valid <= done && (state == BUSY_IF);
      dm_valid <= done && (state == BUSY_DM);
      if (done && state == BUSY_IF) if_rdata <= mem_rdata;
      if (done && state == BUSY_DM) dm_rdata <= cur_we ? '0 : mem_rdata;
    end
  end

  // Gated by rst so every output reads 0 while reset is held.
  assign stall_fe  = ~rst & if_req & ~if_valid;
  assign stall_mem = ~rst & dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32, DATA_W = 32, MEM_LAT = 2, STARVE_MAX = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0, dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic if_ready, if_valid, dm_ready, dm_valid, mem_en, mem_we, stall_fe, stall_mem;
  logic [DATA_W-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT),
                     .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_fe(stall_fe), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, tb_cyc = 0;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, tb_cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [13:0] idx);
    return (idx == 14'd64) ? 32'h00A00093 : 32'h1000_0000 + {18'd0, idx};
  endfunction

  // Synchronous-read memory: data for an access appears the cycle after mem_en.
  logic [31:0] wr_mem [logic [13:0]];
  logic [31:0] rd_q = 32'hBAD0BAD0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_mem[mem_addr[15:2]] = mem_wdata;
      rd_q <= 32'hBAD0BAD0;
    end else if (mem_en) begin
      rd_q <= wr_mem.exists(mem_addr[15:2]) ? wr_mem[mem_addr[15:2]] : init_val(mem_addr[15:2]);
    end else begin
      rd_q <= 32'hBAD0BAD0;
    end
  end
  assign mem_rdata = rd_q;

  // Reference model: absolute cycle bookkeeping of the single outstanding access.
  logic [31:0] ref_wr [logic [13:0]];
  bit m_busy = 0, m_is_if = 0, can_arb = 0, pick_if = 0, pick_dm = 0;
  logic [31:0] m_data = '0;
  int m_done = 0, m_cyc = 0, m_starve = 0;
  logic exp_if_ready = 0, exp_dm_ready = 0, exp_mem_en = 0, exp_mem_we = 0;
  logic exp_if_valid = 0, exp_dm_valid = 0;
  logic [31:0] exp_mem_addr = '0, exp_mem_wdata = '0, exp_if_rdata = '0, exp_dm_rdata = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_starve = 0;
      exp_if_ready = 0; exp_dm_ready = 0; exp_mem_en = 0; exp_mem_we = 0;
      exp_if_valid = 0; exp_dm_valid = 0;
    end else begin
      exp_if_ready = 0; exp_dm_ready = 0; exp_mem_en = 0; exp_mem_we = 0;
      exp_if_valid = 0; exp_dm_valid = 0;
      can_arb = !m_busy;
      if (m_busy && m_cyc == m_done) begin
        if (m_is_if) begin exp_if_valid = 1; exp_if_rdata = m_data; end
        else begin exp_dm_valid = 1; exp_dm_rdata = m_data; end
        m_busy = 0;
        can_arb = 1;
      end
      pick_if = can_arb && if_req && (!dm_req || m_starve == STARVE_MAX);
      pick_dm = can_arb && dm_req && !pick_if;
      if (pick_if || pick_dm) begin
        exp_mem_en   = 1;
        exp_if_ready = pick_if;
        exp_dm_ready = pick_dm;
        exp_mem_addr = pick_if ? if_addr : dm_addr;
        exp_mem_we   = pick_dm && dm_we;
        if (exp_mem_we) begin
          exp_mem_wdata = dm_wdata;
          m_data = '0;
          ref_wr[dm_addr[15:2]] = dm_wdata;
        end else begin
          m_data = ref_wr.exists(exp_mem_addr[15:2]) ? ref_wr[exp_mem_addr[15:2]]
                                                      : init_val(exp_mem_addr[15:2]);
        end
        m_is_if = pick_if;
        m_busy  = 1;
        m_done  = m_cyc + MEM_LAT;
      end
      if (!if_req || pick_if) m_starve = 0;
      else if (pick_dm && m_starve < STARVE_MAX) m_starve = m_starve + 1;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    check("if_ready", if_ready, exp_if_ready);
    check("dm_ready", dm_ready, exp_dm_ready);
    check("mem_en", mem_en, exp_mem_en);
    check("if_valid", if_valid, exp_if_valid);
    check("dm_valid", dm_valid, exp_dm_valid);
    check("stall_fe", stall_fe, !rst && if_req && !exp_if_valid);
    check("stall_mem", stall_mem, !rst && dm_req && !exp_dm_valid);
    if (exp_mem_en) begin
      check("mem_we", mem_we, exp_mem_we);
      check("mem_addr", mem_addr, exp_mem_addr);
      if (exp_mem_we) check("mem_wdata", mem_wdata, exp_mem_wdata);
    end
    if (exp_if_valid) check("if_rdata", if_rdata, exp_if_rdata);
    if (exp_dm_valid) check("dm_rdata", dm_rdata, exp_dm_rdata);
  end

  task automatic wait_grant(input bit want_if, output int t);
    t = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #2;
      if (want_if ? if_ready : dm_ready) begin
        t = tb_cyc;
        break;
      end
    end
    check("grant_timeout", t >= 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  bit eo[6] = '{0, 0, 1, 0, 0, 1};
  int es[6] = '{1, 2, 0, 1, 2, 0};

  initial begin
    int t, r, got;
    int gc[6];
    bit gi[6];
    logic [3:0] gs[6];

    repeat (2) @(posedge clk); #2;
    check("rst_pulses", {if_ready, dm_ready, if_valid, dm_valid, mem_en, mem_we, stall_fe, stall_mem}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_starve", dut.u_arb.starve_cnt, 0);
    check("rst_lat_cnt", dut.lat_cnt, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // IF only: request held through completion
    #1 if_req = 1; if_addr = 32'h100;
    wait_grant(1, t);
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_we", mem_we, 0);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_stall_t0", stall_fe, 1);
    @(posedge clk); #2;
    check("t1_stall_t1", stall_fe, 1);
    check("t1_valid_t1", if_valid, 0);
    @(posedge clk); #2;
    check("t1_valid_t2", if_valid, 1);
    check("t1_rdata", if_rdata, 32'h00A00093);
    check("t1_stall_t2", stall_fe, 0);
    check("t1_latency", tb_cyc - t, 2);
    if_req = 0;
    repeat (4) @(posedge clk);

    // DM store
    #1 dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
    wait_grant(0, t);
    check("t2_mem_we", mem_we, 1);
    check("t2_mem_addr", mem_addr, 32'h2000);
    check("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("t2_stall_mem", stall_mem, 1);
    dm_req = 0; dm_we = 0;
    @(posedge clk); #2;
    check("t2_valid_t1", dm_valid, 0);
    @(posedge clk); #2;
    check("t2_valid_t2", dm_valid, 1);
    check("t2_rdata", dm_rdata, 0);
    check("t2_mem_written", wr_mem.exists(14'h800) ? wr_mem[14'h800] : 32'h0, 32'hDEADBEEF);
    repeat (3) @(posedge clk);

    // back-to-back loads
    #1 dm_req = 1; dm_we = 0; dm_addr = 32'h10;
    wait_grant(0, t);
    dm_addr = 32'h14;
    @(posedge clk); #2;
    check("t4_gap_en", mem_en, 0);
    @(posedge clk); #2;
    check("t4_second_en", mem_en, 1);
    check("t4_second_ready", dm_ready, 1);
    check("t4_second_addr", mem_addr, 32'h14);
    check("t4_first_valid", dm_valid, 1);
    check("t4_first_rdata", dm_rdata, 32'h10000004);
    dm_req = 0;
    @(posedge clk); #2;
    check("t4_gap_en2", mem_en, 0);
    @(posedge clk); #2;
    check("t4_second_valid", dm_valid, 1);
    check("t4_second_rdata", dm_rdata, 32'h10000005);
    repeat (3) @(posedge clk);

    // both requesters held continuously
    #1 if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
    got = 0;
    for (int n = 0; n < 40 && got < 6; n++) begin
      @(posedge clk); #2;
      if (if_ready || dm_ready) begin
        gi[got] = if_ready;
        gc[got] = tb_cyc;
        gs[got] = dut.u_arb.starve_cnt;
        got++;
      end
    end
    if_req = 0; dm_req = 0;
    check("t3_grant_count", got, 6);
    for (int i = 0; i < got; i++) begin
      check($sformatf("t3_order%0d", i), gi[i], eo[i]);
      check($sformatf("t3_starve%0d", i), gs[i], es[i]);
      if (i > 0) check($sformatf("t3_spacing%0d", i), gc[i] - gc[i-1], 2);
    end
    repeat (4) @(posedge clk);

    // simultaneous rise, single DM request
    #1 if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h30;
    t = -1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #2;
      if (if_ready || dm_ready) begin t = tb_cyc; break; end
      check("t6_stall_wait", stall_fe, 1);
    end
    check("t6_first_dm", {if_ready, dm_ready}, 2'b01);
    dm_req = 0;
    @(posedge clk); #2;
    check("t6_stall_t1", stall_fe, 1);
    check("t6_if_not_yet", if_ready, 0);
    @(posedge clk); #2;
    check("t6_if_ready", if_ready, 1);
    check("t6_stall_t2", stall_fe, 1);
    check("t6_if_delay", tb_cyc - t, 2);
    if_req = 0;
    repeat (4) @(posedge clk);

    // reset one cycle after an IF grant, request still held at release
    #1 if_req = 1; if_addr = 32'h104;
    wait_grant(1, t);
    @(posedge clk); #2;
    rst = 1;
    #1;
    check("t5_pulses", {if_ready, dm_ready, if_valid, dm_valid, mem_en, mem_we, stall_fe, stall_mem}, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_mem_wdata", mem_wdata, 0);
    check("t5_if_rdata", if_rdata, 0);
    check("t5_dm_rdata", dm_rdata, 0);
    check("t5_lat_cnt", dut.lat_cnt, 0);
    repeat (2) @(posedge clk); #2;
    rst = 0;
    r = tb_cyc;
    #1;
    check("t5_rel_valid", if_valid, 0);
    check("t5_rel_ready", if_ready, 0);
    @(posedge clk); #2;
    check("t5_regrant", if_ready, 1);
    check("t5_regrant_delay", tb_cyc - r, 1);
    check("t5_no_stale_valid1", if_valid, 0);
    if_req = 0;
    @(posedge clk); #2;
    check("t5_no_stale_valid2", if_valid, 0);
    @(posedge clk); #2;
    check("t5_new_valid", if_valid, 1);
    check("t5_new_rdata", if_rdata, 32'h10000041);
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
